// File: rtl/risc_run_controller.sv
// Run/step controller for the Simple RISC core: sequences core reset, gates core
// execution with a clock enable, and ends a run on halt or on an exhausted cycle budget.
module risc_run_controller #(
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 1000,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt_in,
    input  logic             retire,
    output logic             core_reset,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        RUN   = 3'd2,
        SWAIT = 3'd3,
        SEXEC = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam int               RST_W       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RST_W-1:0] RST_LOAD    = RST_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1'b1);

    state_t           state_r;
    logic             mode_r;
    logic [RST_W-1:0] rst_cnt_r;

    logic [CNT_W-1:0] cyc_next_s;
    logic [CNT_W-1:0] ret_next_s;
    logic             budget_hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != CNT_MAX)) begin
            return v + CNT_ONE;
        end else begin
            return v;
        end
    endfunction

    // Counter updates and budget test for an enabled core cycle
    always_comb begin
        cyc_next_s   = sat_inc(cycle_count, 1'b1);
        ret_next_s   = sat_inc(retire_count, retire);
        budget_hit_s = (cycle_count >= BUDGET_LAST);
    end

    // Run sequencer with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            mode_r       <= 1'b0;
            rst_cnt_r    <= {RST_W{1'b0}};
            core_reset   <= 1'b1;
            core_en      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= {CNT_W{1'b0}};
            retire_count <= {CNT_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r      <= RST;
                        mode_r       <= step_mode;
                        rst_cnt_r    <= RST_LOAD;
                        cycle_count  <= {CNT_W{1'b0}};
                        retire_count <= {CNT_W{1'b0}};
                        timeout      <= 1'b0;
                        busy         <= 1'b1;
                        core_reset   <= 1'b1;
                        core_en      <= 1'b0;
                    end
                end
                RST: begin
                    if (rst_cnt_r == {RST_W{1'b0}}) begin
                        core_reset <= 1'b0;
                        if (mode_r) begin
                            state_r <= SWAIT;
                        end else begin
                            state_r <= RUN;
                            core_en <= 1'b1;
                        end
                    end else begin
                        rst_cnt_r <= rst_cnt_r - RST_W'(1'b1);
                    end
                end
                RUN, SEXEC: begin
                    // halt and retire only matter here, where core_en is high
                    cycle_count  <= cyc_next_s;
                    retire_count <= ret_next_s;
                    if (halt_in || budget_hit_s) begin
                        state_r <= FIN;
                        timeout <= ~halt_in;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        core_en <= 1'b0;
                    end else if (state_r == SEXEC) begin
                        state_r <= SWAIT;
                        core_en <= 1'b0;
                    end
                end
                SWAIT: begin
                    if (step) begin
                        state_r <= SEXEC;
                        core_en <= 1'b1;
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    core_en <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/risc_run_controller.md
Name: risc_run_controller

Overview:
- Synthesizable run/step controller that sits between the board-level clock/reset and the Simple RISC processor core.
- Sequences the core's reset, gates its execution with a clock enable, and stops a run on halt or on a cycle budget.
- Counts executed cycles and retired instructions.
- Parametrised in reset length, cycle budget and counter width; adds a single-step mode, which the fixed-length hand-driven run flow lacks.

Parameters:
- RST_CYCLES, 2: cycles core_reset stays asserted after start (>=1).
- MAX_CYCLES, 1000: budget of enabled core cycles before timeout (>=1, < 2^CNT_W).
- CNT_W, 32: width of cycle_count and retire_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset of this block.
- start  in  1  one-cycle pulse that begins a run; ignored while busy=1.
- step_mode  in  1  sampled with start; 1 = single-step run.
- step  in  1  in step mode, requests exactly one enabled core cycle.
- halt_in  in  1  from core: halt instruction retired this cycle.
- retire  in  1  from core: one instruction retired this cycle.
- core_reset  out  1  synchronous reset to core.
- core_en  out  1  clock enable to core.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- timeout  out  1  sticky; last run ended on budget exhaustion.
- cycle_count  out  CNT_W  enabled core cycles in current/last run.
- retire_count  out  CNT_W  retired instructions in current/last run.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset. All outputs are registered.
- Reset values: state=IDLE, core_reset=1, core_en=0, busy=0, done=0, timeout=0, both counts=0.
- Reset asserted mid-run aborts to these values on the next edge, with no done pulse.
- States: IDLE, RST, RUN, SWAIT, SEXEC, FIN.
- IDLE:
  - core_en=0, busy=0. core_reset keeps its last value: 1 after reset, 0 after a finished run, so core state stays inspectable.
  - start=1 -> RST: latch step_mode, clear counts and timeout, load reset counter.
- RST:
  - core_reset=1, core_en=0, busy=1 for exactly RST_CYCLES cycles.
  - Then -> RUN if latched mode=0, else -> SWAIT.
  - Latency: start sampled at edge k; busy=1 from edge k+1; core_en first 1 at edge k+1+RST_CYCLES.
- RUN:
  - core_reset=0, core_en=1.
  - Every cycle: cycle_count+1; retire_count+1 when retire=1.
  - halt_in=1 -> FIN, timeout=0.
  - Else, when this is the MAX_CYCLES-th enabled cycle -> FIN, timeout=1.
  - halt_in and budget exhaustion in the same cycle: halt wins, timeout=0. That cycle is still counted.
- SWAIT:
  - core_reset=0, core_en=0, busy=1. Counters hold.
  - step=1 -> SEXEC. step held high yields one step per SWAIT/SEXEC pair, i.e. at most one enabled cycle every 2 clocks.
- SEXEC:
  - One cycle with core_en=1. Counting, halt and timeout rules identical to RUN.
  - Then -> FIN on halt/timeout, else -> SWAIT.
- FIN:
  - done=1 for exactly one cycle; busy=0, core_en=0, core_reset=0. Then -> IDLE.
  - start during FIN is ignored.
- halt_in and retire are ignored whenever core_en=0.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- Counts and timeout hold after FIN until the next accepted start.
- start while busy=1 has no effect on state, counters or mode.

Test Plan:
1. Reset held 3 cycles, then released; no start for 10 cycles -> core_reset=1, core_en=0, busy=0, done=0, counts=0 throughout.
2. Defaults, start pulse at cycle 0, step_mode=0, retire=1 every cycle, halt_in=1 on 5th enabled cycle -> core_reset high cycles 1-2, core_en high cycles 3-7, done pulse cycle 8, cycle_count=5, retire_count=5, timeout=0, core_reset stays 0 in IDLE.
3. MAX_CYCLES=4, no halt, retire on alternate cycles -> exactly 4 core_en cycles, done once, timeout=1, cycle_count=4, retire_count=2. Next start clears timeout to 0.
4. MAX_CYCLES=4, halt_in=1 on 4th enabled cycle -> timeout=0, cycle_count=4.
5. step_mode=1, three step pulses 5 cycles apart, then halt on 3rd step -> core_en high exactly 3 single cycles, one per step; counters static between steps; done after 3rd step. Extra start pulses during the run are ignored.
6. CNT_W=3, MAX_CYCLES=7, retire=1 every cycle, plus reset asserted mid-run (cycle_count=4) -> first run: counts saturate/stop at 7 with timeout=1; mid-run reset: next edge returns all outputs to reset values, no done pulse.
